frame_bank_scheduler: RTL and testbench

Triple-buffer bank scheduler for the shared pixel frame buffer. Sits between the camera capture path, the frame-buffer BRAM and the VGA read path, all in the 25 MHz domain. Camera pixels always go to a free bank. The VGA side always reads the newest complete frame. Bank ownership changes only at frame boundaries, so displayed frames never tear.

---
 rtl/fb_pkg.sv | 34 +++
 rtl/fb_bank_rotator.sv | 100 ++++++++++
 rtl/frame_bank_scheduler.sv | 153 +++++++++++++++
 tb/tb_frame_bank_scheduler.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types and constants for the frame-bank scheduler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// The scalar defaults here describe the 640x480, 3:3:3 RGB build. Modules take
// them as parameter defaults so a smaller frame can be built for bring-up.
package fb_pkg;

  localparam int FRAME_PIXELS = 307200;
  localparam int PIX_W        = 9;
  localparam int IDX_W        = 19;
  localparam int ADDR_W       = 20;

  // Write-side framing state.
  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } wr_state_t;

  // One of the three frame banks in the shared BRAM.
  typedef logic [1:0] bank_t;

  // Bank ownership out of reset: camera writes bank 0, bank 1 is the spare,
  // bank 2 is scanned out (and flagged invalid until a real frame lands there).
  localparam bank_t BANK_W_RST = 2'd0;
  localparam bank_t BANK_P_RST = 2'd1;
  localparam bank_t BANK_R_RST = 2'd2;

  // Bank base addresses for the default frame size.
  localparam int BASE0 = 0;
  localparam int BASE1 = FRAME_PIXELS;
  localparam int BASE2 = 2 * FRAME_PIXELS;

endpackage

// File: rtl/fb_bank_rotator.sv
// Triple-buffer bank ownership: rotates write/pending/read banks on publish and read swap.
// Latency: bank and base changes take effect at the edge that samples the pulse.
// Backpressure: none; a swap request with no pending frame is simply ignored.
//
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   publish_i      write side finished a complete frame in the W bank
//   swap_i         display side is at its frame boundary and may take a new frame
//   w_base_o       registered base address of the write bank
//   r_base_o       registered base address of the read bank
//   skip_inc_o     a pending, never-displayed frame is being overwritten this cycle
//   rd_valid_o     the read bank has held a complete frame at least once since reset
module fb_bank_rotator
  import fb_pkg::*;
#(
  parameter int FRAME_PIXELS = fb_pkg::FRAME_PIXELS,
  parameter int ADDR_W       = fb_pkg::ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              publish_i,
  input  logic              swap_i,
  output logic [ADDR_W-1:0] w_base_o,
  output logic [ADDR_W-1:0] r_base_o,
  output logic              skip_inc_o,
  output logic              rd_valid_o
);

  // Bases are elaboration-time constants, so no multiplier is built.
  localparam logic [ADDR_W-1:0] B0_C = '0;
  localparam logic [ADDR_W-1:0] B1_C = ADDR_W'(FRAME_PIXELS);
  localparam logic [ADDR_W-1:0] B2_C = ADDR_W'(2 * FRAME_PIXELS);

  function automatic logic [ADDR_W-1:0] base_of(input bank_t b);
    case (b)
      2'd0:    base_of = B0_C;
      2'd1:    base_of = B1_C;
      default: base_of = B2_C;
    endcase
  endfunction

  bank_t             w_q, w_d, p_q, p_d, r_q, r_d;
  logic              pend_q, pend_d;
  logic              rd_valid_q, rd_valid_d;
  logic [ADDR_W-1:0] w_base_q, r_base_q;

  always_comb begin
    w_d        = w_q;
    p_d        = p_q;
    r_d        = r_q;
    pend_d     = pend_q;
    rd_valid_d = rd_valid_q;
    skip_inc_o = 1'b0;
    if (publish_i && swap_i) begin
      // The frame just finished goes straight to display; any older pending
      // frame falls back into the write slot unseen.
      r_d        = w_q;
      w_d        = p_q;
      p_d        = r_q;
      pend_d     = 1'b0;
      rd_valid_d = 1'b1;
      skip_inc_o = pend_q;
    end else if (publish_i) begin
      p_d        = w_q;
      w_d        = p_q;
      pend_d     = 1'b1;
      skip_inc_o = pend_q;
    end else if (swap_i && pend_q) begin
      r_d        = p_q;
      p_d        = r_q;
      pend_d     = 1'b0;
      rd_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_q        <= BANK_W_RST;
      p_q        <= BANK_P_RST;
      r_q        <= BANK_R_RST;
      pend_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      w_base_q   <= base_of(BANK_W_RST);
      r_base_q   <= base_of(BANK_R_RST);
    end else begin
      w_q        <= w_d;
      p_q        <= p_d;
      r_q        <= r_d;
      pend_q     <= pend_d;
      rd_valid_q <= rd_valid_d;
      w_base_q   <= base_of(w_d);
      r_base_q   <= base_of(r_d);
    end
  end

  assign w_base_o   = w_base_q;
  assign r_base_o   = r_base_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/frame_bank_scheduler.sv
// Triple-buffer scheduler between camera capture, the shared frame BRAM and VGA scan-out.
// Latency: camera pixel to BRAM write 1 cycle; VGA index to BRAM read address 0 cycles.
// Backpressure: none; pixels are taken every cycle, unframed or past-end pixels are dropped.
//
// Ports:
//   i_clk25m, i_rstn_clk25m           pixel clock, async active-low reset
//   i_wr_valid/_data/_sof/_eof        camera pixel stream with frame markers
//   o_wr_en/_addr/_data               BRAM write port (registered)
//   i_rd_frame_start                  VGA end-of-active-video pulse, the only safe swap point
//   i_rd_addr / o_rd_addr             in-bank read index / absolute BRAM read address
//   o_rd_frame_valid                  read bank holds a real frame (else VGA shows black)
//   o_frames_dropped/_skipped         saturating error/statistics counters
module frame_bank_scheduler
  import fb_pkg::*;
#(
  parameter int FRAME_PIXELS = fb_pkg::FRAME_PIXELS,
  parameter int PIX_W        = fb_pkg::PIX_W,
  parameter int IDX_W        = fb_pkg::IDX_W,
  parameter int ADDR_W       = fb_pkg::ADDR_W
) (
  input  logic              i_clk25m,
  input  logic              i_rstn_clk25m,
  input  logic              i_wr_valid,
  input  logic [PIX_W-1:0]  i_wr_data,
  input  logic              i_wr_sof,
  input  logic              i_wr_eof,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [PIX_W-1:0]  o_wr_data,
  input  logic              i_rd_frame_start,
  input  logic [IDX_W-1:0]  i_rd_addr,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic              o_rd_frame_valid,
  output logic [7:0]        o_frames_dropped,
  output logic [7:0]        o_frames_skipped
);

  // One spare bit so the pixel count can reach FRAME_PIXELS and park there.
  localparam int               CNT_W  = IDX_W + 1;
  localparam logic [CNT_W-1:0] FP_C   = CNT_W'(FRAME_PIXELS);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(FRAME_PIXELS - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  wr_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [PIX_W-1:0]  wr_data_q, wr_data_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;
  logic [7:0]        skip_cnt_q, skip_cnt_d;
  logic [CNT_W-1:0]  idx;
  logic              publish, abort_drop, eof_drop;
  logic [8:0]        drop_sum;
  logic [ADDR_W-1:0] w_base, r_base;
  logic              skip_inc;
  logic              rd_valid;

  fb_bank_rotator #(
    .FRAME_PIXELS (FRAME_PIXELS),
    .ADDR_W       (ADDR_W)
  ) u_rotator (
    .clk_i      (i_clk25m),
    .rst_ni     (i_rstn_clk25m),
    .publish_i  (publish),
    .swap_i     (i_rd_frame_start),
    .w_base_o   (w_base),
    .r_base_o   (r_base),
    .skip_inc_o (skip_inc),
    .rd_valid_o (rd_valid)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    wr_en_d    = 1'b0;
    idx        = '0;
    publish    = 1'b0;
    abort_drop = 1'b0;
    eof_drop   = 1'b0;
    if (i_wr_valid) begin
      if (i_wr_sof) begin
        // A sof always restarts at index 0; if a frame was in flight it is lost.
        abort_drop = (state_q == CAPTURE);
        wr_en_d    = 1'b1;
        cnt_d      = ONE_C;
        ovf_d      = 1'b0;
        state_d    = CAPTURE;
        if (i_wr_eof) begin
          state_d  = IDLE;
          publish  = (FRAME_PIXELS == 1);
          eof_drop = (FRAME_PIXELS != 1);
        end
      end else if (state_q == CAPTURE) begin
        if (cnt_q < FP_C) begin
          wr_en_d = 1'b1;
          idx     = cnt_q;
          cnt_d   = cnt_q + ONE_C;
        end else begin
          // Never write past the bank end; remember so the frame gets dropped.
          ovf_d = 1'b1;
        end
        if (i_wr_eof) begin
          state_d  = IDLE;
          publish  = (cnt_q == LAST_C) && !ovf_q;
          eof_drop = !((cnt_q == LAST_C) && !ovf_q);
        end
      end
    end
  end

  // Address is formed from the W base as it stands before this edge, so the
  // eof pixel of a publishing frame still lands in its own bank.
  assign wr_addr_d = wr_en_d ? (w_base + ADDR_W'(idx)) : wr_addr_q;
  assign wr_data_d = wr_en_d ? i_wr_data : wr_data_q;

  // An abort and a 1-pixel drop can coincide, hence a 2-bit increment.
  assign drop_sum   = {1'b0, drop_cnt_q} + {8'd0, abort_drop} + {8'd0, eof_drop};
  assign drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  assign skip_cnt_d = (skip_inc && (skip_cnt_q != 8'hFF)) ? (skip_cnt_q + 8'd1) : skip_cnt_q;

  always_ff @(posedge i_clk25m or negedge i_rstn_clk25m) begin
    if (!i_rstn_clk25m) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      drop_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      drop_cnt_q <= drop_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign o_wr_en          = wr_en_q;
  assign o_wr_addr        = wr_addr_q;
  assign o_wr_data        = wr_data_q;
  assign o_rd_addr        = r_base + ADDR_W'(i_rd_addr);
  assign o_rd_frame_valid = rd_valid;
  assign o_frames_dropped = drop_cnt_q;
  assign o_frames_skipped = skip_cnt_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
`timescale 1ns/1ps
module tb_frame_bank_scheduler;

  localparam int FP = 16;
  localparam int PW = 9;
  localparam int IW = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_valid = 1'b0;
  logic [PW-1:0] wr_data = '0;
  logic          wr_sof = 1'b0;
  logic          wr_eof = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_dat;
  logic          rd_start = 1'b0;
  logic [IW-1:0] rd_idx = '0;
  logic [AW-1:0] rd_addr;
  logic          rd_fv;
  logic [7:0]    dropped;
  logic [7:0]    skipped;

  always #20 clk = ~clk;

  frame_bank_scheduler #(
    .FRAME_PIXELS (FP),
    .PIX_W        (PW),
    .IDX_W        (IW),
    .ADDR_W       (AW)
  ) dut (
    .i_clk25m         (clk),
    .i_rstn_clk25m    (rst_n),
    .i_wr_valid       (wr_valid),
    .i_wr_data        (wr_data),
    .i_wr_sof         (wr_sof),
    .i_wr_eof         (wr_eof),
    .o_wr_en          (wr_en),
    .o_wr_addr        (wr_addr),
    .o_wr_data        (wr_dat),
    .i_rd_frame_start (rd_start),
    .i_rd_addr        (rd_idx),
    .o_rd_addr        (rd_addr),
    .o_rd_frame_valid (rd_fv),
    .o_frames_dropped (dropped),
    .o_frames_skipped (skipped)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  m_w, m_p, m_r;        // bank numbers owned by writer / pending / reader
  bit  m_pend, m_rdv;
  int  m_drop, m_skip;
  bit  m_in_frame;
  int  m_tot;                // pixels received in the current frame
  int  checks = 0;
  int  passes = 0;
  bit  mon_en = 1'b0;

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: dut=%0d model=%0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_w = 0; m_p = 1; m_r = 2;
    m_pend = 1'b0; m_rdv = 1'b0;
    m_drop = 0; m_skip = 0;
    m_in_frame = 1'b0; m_tot = 0;
    exp_q.delete();
  endtask

  // A frame is good iff exactly FP pixels arrive from sof to eof.
  task automatic model_step(input bit vld, input logic [PW-1:0] d, input bit sof,
                            input bit eof, input bit start);
    bit  pub;
    int  t;
    wr_t e;
    pub = 1'b0;
    if (vld) begin
      if (sof) begin
        if (m_in_frame) m_drop = sat(m_drop + 1);
        m_in_frame = 1'b1;
        m_tot = 0;
      end
      if (m_in_frame) begin
        if (m_tot < FP) begin
          e.addr = AW'(m_w * FP + m_tot);
          e.data = d;
          exp_q.push_back(e);
        end
        m_tot++;
        if (eof) begin
          m_in_frame = 1'b0;
          if (m_tot == FP) pub = 1'b1;
          else m_drop = sat(m_drop + 1);
        end
      end
    end
    if (pub) begin
      if (m_pend) m_skip = sat(m_skip + 1);
      if (start) begin
        t = m_r; m_r = m_w; m_w = m_p; m_p = t;
        m_pend = 1'b0; m_rdv = 1'b1;
      end else begin
        t = m_w; m_w = m_p; m_p = t;
        m_pend = 1'b1;
      end
    end else if (start && m_pend) begin
      t = m_r; m_r = m_p; m_p = t;
      m_pend = 1'b0; m_rdv = 1'b1;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    wr_t e;
    bit  exp_en;
    if (mon_en) begin
      exp_en = (exp_q.size() != 0);
      chk("wr_en", {31'd0, wr_en}, {31'd0, exp_en});
      if (exp_en) begin
        e = exp_q.pop_front();
        if (wr_en === 1'b1) begin
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", 32'(wr_dat), 32'(e.data));
        end
      end
      chk("rd_addr", 32'(rd_addr), 32'(m_r * FP + int'(rd_idx)));
      chk("rd_frame_valid", {31'd0, rd_fv}, {31'd0, m_rdv});
      chk("frames_dropped", 32'(dropped), 32'(m_drop));
      chk("frames_skipped", 32'(skipped), 32'(m_skip));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit vld, input bit sof, input bit eof, input bit start);
    logic [PW-1:0] d;
    d        = PW'($urandom);
    wr_valid = vld;
    wr_data  = d;
    wr_sof   = sof;
    wr_eof   = eof;
    rd_start = start;
    rd_idx   = IW'($urandom);
    @(posedge clk);
    #1;
    model_step(vld, d, sof, eof, start);
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
    wr_eof   = 1'b0;
    rd_start = 1'b0;
  endtask

  task automatic idle(input int n, input bit start_last);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, start_last && (i == n - 1));
  endtask

  task automatic send_frame(input int n, input int start_at, input bit with_eof, input int gap_pct);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(99) < gap_pct) step(1'b0, 1'b0, 1'b0, $urandom_range(15) == 0);
      step(1'b1, i == 0, with_eof && (i == n - 1), i == start_at);
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    model_reset();
    rd_idx = 4'd7;
    #50;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_dat), 32'd0);
    chk("rst_rd_frame_valid", {31'd0, rd_fv}, 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);
    chk("rst_skipped", 32'(skipped), 32'd0);
    chk("rst_rd_addr", 32'(rd_addr), 32'(m_r * FP + 7));
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(3, 1'b1);                 // swap request with nothing pending: ignored

    send_frame(16, -1, 1'b1, 0);   // first good frame, published
    idle(3, 1'b0);
    idle(2, 1'b1);                 // display takes it
    send_frame(16, -1, 1'b1, 0);   // next frame lands in the new write bank
    send_frame(10, -1, 1'b1, 0);   // short frame
    send_frame(20, -1, 1'b1, 0);   // long frame, tail not written
    send_frame(7, -1, 1'b0, 0);    // aborted by the following sof
    send_frame(16, -1, 1'b1, 0);
    send_frame(16, -1, 1'b1, 0);   // overwrites an undisplayed frame
    send_frame(16, 15, 1'b1, 0);   // eof and swap on the same cycle
    idle(3, 1'b0);

    step(1'b1, 1'b1, 1'b1, 1'b0);  // 1-pixel frame from idle
    send_frame(5, -1, 1'b0, 0);
    step(1'b1, 1'b1, 1'b1, 1'b0);  // 1-pixel frame that also aborts

    send_frame(9, -1, 1'b0, 0);    // partial frame, then reset mid-frame
    do_reset();
    send_frame(16, -1, 1'b1, 10);
    idle(2, 1'b1);

    repeat (80) begin
      int r;
      int n;
      r = $urandom_range(9);
      if (r < 6)       n = 16;
      else if (r == 6) n = $urandom_range(1, 15);
      else if (r == 7) n = $urandom_range(17, 22);
      else             n = 16;
      send_frame(n, ($urandom_range(3) == 0) ? $urandom_range(0, n - 1) : -1, r != 9, 20);
      if ($urandom_range(3) == 0) step(1'b1, 1'b0, $urandom_range(1) == 1, 1'b0);
      idle($urandom_range(0, 3), $urandom_range(2) == 0);
    end

    repeat (260) step(1'b1, 1'b1, 1'b1, 1'b0);          // drop counter saturates
    repeat (258) send_frame(16, -1, 1'b1, 0);           // skip counter saturates
    idle(2, 1'b1);
    send_frame(16, 15, 1'b1, 0);
    idle(4, 1'b0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
